// File: rtl/memory_stage_pkg.sv
// Shared Y86-64 constants for the memory stage: instruction codes and status values.
package y86_pkg;

    localparam int unsigned MEM_WORDS_DEF = 1024;
    localparam int unsigned DATA_W_DEF    = 64;

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic STAT_OK  = 1'b0;
    localparam logic STAT_ERR = 1'b1;

endpackage

// File: rtl/memory_stage_if.sv
// Memory-stage bus: decoded-instruction inputs from fetch/execute, valM/stat back to the core.
interface memory_stage_if #(
    parameter int unsigned DATA_W = 64
);
    logic [3:0]        icode;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valP;
    logic              instr_valid;
    logic              imem_error;
    logic [DATA_W-1:0] valM;
    logic              stat;

    modport master (
        output icode, valE, valA, valP, instr_valid, imem_error,
        input  valM, stat
    );

    modport slave (
        input  icode, valE, valA, valP, instr_valid, imem_error,
        output valM, stat
    );
endinterface

// File: rtl/memory_stage_dmem_array.sv
// Word-addressed data memory: async read, sync write with enable, synchronous whole-array clear.
module dmem_array #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_stage.sv
// Y86-64 SEQ memory stage: op decode, address/data muxing, range check and status.
// Optional macro DMEM_STICKY_ERR_EN makes stat latch on the first error until reset.
module memory_stage
    import y86_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    memory_stage_if.slave  mif
);

    localparam int unsigned       AW        = $clog2(MEM_WORDS);
    localparam logic [DATA_W-1:0] MEM_LIMIT = DATA_W'(MEM_WORDS);

    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              fetch_err;
    logic              addr_bad;
    logic              err_now;
    logic              err_q;
    logic              wr_en;
    logic              rd_ok;

    always_comb begin
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        addr   = mif.valE;
        wdata  = mif.valA;
        case (mif.icode)
            I_RMMOVQ: mem_wr = 1'b1;
            I_MRMOVQ: mem_rd = 1'b1;
            I_CALL: begin
                mem_wr = 1'b1;
                wdata  = mif.valP;
            end
            I_RET: begin
                mem_rd = 1'b1;
                addr   = mif.valA;
            end
            I_PUSHQ:  mem_wr = 1'b1;
            I_POPQ: begin
                mem_rd = 1'b1;
                addr   = mif.valA;
            end
            default: ;
        endcase
    end

    // Negative addresses show up as a set sign bit; anything else is compared unsigned.
    assign fetch_err = mif.imem_error | ~mif.instr_valid;
    assign addr_bad  = (mem_rd | mem_wr) & (addr[DATA_W-1] | (addr >= MEM_LIMIT));
    assign err_now   = fetch_err | addr_bad;

`ifdef DMEM_STICKY_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_now) begin
            err_q <= 1'b1;
        end
    end
`else
    assign err_q = 1'b0;
`endif

    assign wr_en = mem_wr & ~err_now & ~err_q & ~reset;
    assign rd_ok = mem_rd & ~err_now & ~reset;

    dmem_array #(
        .MEM_WORDS (MEM_WORDS),
        .DATA_W    (DATA_W),
        .AW        (AW)
    ) u_dmem (
        .clk   (clk),
        .clr   (reset),
        .we    (wr_en),
        .waddr (addr[AW-1:0]),
        .wdata (wdata),
        .raddr (addr[AW-1:0]),
        .rdata (rdata)
    );

    assign mif.valM = rd_ok ? rdata : '0;
    assign mif.stat = reset ? STAT_OK : ((err_now | err_q) ? STAT_ERR : STAT_OK);

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios then random ops against an array model.
module tb_memory_stage;

    localparam int MEM_WORDS = 1024;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [63:0] model_mem [MEM_WORDS];
    logic        model_sticky;

    memory_stage_if #(.DATA_W(64)) mif ();

    memory_stage #(.MEM_WORDS(MEM_WORDS), .DATA_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one instruction shortly after a rising edge, check outputs mid-cycle, then
    // advance the reference memory across the next edge.
    task automatic step(input string tag, input logic [3:0] icode, input logic [63:0] ve,
                        input logic [63:0] va, input logic [63:0] vp,
                        input logic iv, input logic ie, input logic rst);
        logic               is_rd, is_wr, err;
        logic signed [63:0] a;
        logic [63:0]        data, exp_m;
        logic               exp_s;
        reset           = rst;
        mif.icode       = icode;
        mif.valE        = ve;
        mif.valA        = va;
        mif.valP        = vp;
        mif.instr_valid = iv;
        mif.imem_error  = ie;
        #2;
        is_rd = (icode == 4'd5) || (icode == 4'd9) || (icode == 4'd11);
        is_wr = (icode == 4'd4) || (icode == 4'd8) || (icode == 4'd10);
        a     = (icode == 4'd9 || icode == 4'd11) ? va : ve;
        data  = (icode == 4'd8) ? vp : va;
        err   = ie || !iv || ((is_rd || is_wr) && (a < 0 || a >= MEM_WORDS));
        if (rst) begin
            exp_m = '0;
            exp_s = 1'b0;
        end else begin
            exp_m = (is_rd && !err) ? model_mem[a[9:0]] : 64'd0;
            exp_s = err || model_sticky;
        end
        check_val({tag, ".valM"}, mif.valM, exp_m);
        check_val({tag, ".stat"}, {63'd0, mif.stat}, {63'd0, exp_s});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = '0;
            model_sticky = 1'b0;
        end else begin
            if (is_wr && !err && !model_sticky) model_mem[a[9:0]] = data;
`ifdef DMEM_STICKY_ERR_EN
            if (err) model_sticky = 1'b1;
`endif
        end
        #1;
    endtask

    initial begin
        logic [3:0]  ic;
        logic [63:0] ad, va, vp;
        int          r;
        model_sticky = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = 64'hDEAD_BEEF;
        reset = 1'b1;
        mif.icode = '0; mif.valE = '0; mif.valA = '0; mif.valP = '0;
        mif.instr_valid = 1'b1; mif.imem_error = 1'b0;
        @(posedge clk);
        #1;

        step("rst",      4'h4, 64'd100, 64'd7,  64'd0, 1, 0, 1);
        step("st49",     4'h4, 64'd100, 64'd49, 64'd0, 1, 0, 0);
        step("ld49",     4'h5, 64'd100, 64'd0,  64'd0, 1, 0, 0);
        step("stneg",    4'h4, 64'd250, -64'sd49, 64'd0, 1, 0, 0);
        step("ldneg",    4'h5, 64'd250, 64'd0,  64'd0, 1, 0, 0);
        step("st99",     4'h4, 64'd100, 64'd99, 64'd0, 1, 0, 0);
        step("ld99",     4'h5, 64'd100, 64'd0,  64'd0, 1, 0, 0);
        step("call",     4'h8, 64'd82,  64'd1,  64'd87, 1, 0, 0);
        step("pop",      4'hB, 64'd0,   64'd82, 64'd0, 1, 0, 0);
        step("retfresh", 4'h9, 64'd0,   64'd99, 64'd0, 1, 0, 0);
        step("wr_oob",   4'h4, 64'd1024, 64'd7, 64'd0, 1, 0, 0);
        step("wr_top",   4'h4, 64'd1023, 64'd5, 64'd0, 1, 0, 0);
        step("rd_top",   4'h5, 64'd1023, 64'd0, 64'd0, 1, 0, 0);
        step("rd_neg",   4'h5, -64'sd1, 64'd0,  64'd0, 1, 0, 0);
        step("invalid",  4'h0, 64'd0,   64'd0,  64'd0, 0, 0, 0);
        step("imemerr",  4'h4, 64'd100, 64'd5,  64'd0, 1, 1, 0);
        step("ld_keep",  4'h5, 64'd100, 64'd0,  64'd0, 1, 0, 0);
        step("push",     4'hA, 64'd3,   64'd11, 64'd0, 1, 0, 0);
        step("rst2",     4'h5, 64'd100, 64'd0,  64'd0, 1, 0, 1);
        step("ld_clr",   4'h5, 64'd100, 64'd0,  64'd0, 1, 0, 0);
        step("ld_clr3",  4'hB, 64'd0,   64'd3,  64'd0, 1, 0, 0);

        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       ad = 64'($urandom_range(0, 31));
            else if (r == 8) ad = 64'(MEM_WORDS + $urandom_range(0, 3));
            else             ad = -64'($urandom_range(1, 5));
            if ($urandom_range(0, 4) == 0) ic = 4'($urandom_range(0, 15));
            else begin
                case ($urandom_range(0, 5))
                    0: ic = 4'h4;
                    1: ic = 4'h5;
                    2: ic = 4'h8;
                    3: ic = 4'h9;
                    4: ic = 4'hA;
                    default: ic = 4'hB;
                endcase
            end
            vp = {$urandom, $urandom};
            va = (ic == 4'h9 || ic == 4'hB) ? ad : {$urandom, $urandom};
            step("rand", ic, ad, va, vp,
                 $urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
